time_display_scan: RTL and testbench
====================================

TIME_DISPLAY_SCAN -- requirements
Module: time_display_scan

Interface
REQ-001 SHALL have parameter REFRESH_DIV, default 100000, meaning clk cycles per digit slot (1 kHz slot rate at 100 MHz); legal range is 2 or more.
REQ-002 SHALL have port clk, input, 1, meaning the 100 MHz system clock; all state advances on its rising edge.
REQ-003 SHALL have port reset, input, 1, meaning the reset; it is asynchronous and active-high.
REQ-004 SHALL have ports hrTensDig, hrOnesDig, minTensDig, minOnesDig, secTensDig, secOnesDig, input, 4 each, meaning the BCD time digits from the timekeeping block.
REQ-005 SHALL have port show_seconds, input, 1: 0 displays HH:MM, 1 displays MM:SS.
REQ-006 SHALL have port blank_lead_zero, input, 1: 1 blanks the leftmost digit when it is 0.
REQ-007 SHALL have port sec_tick, input, 1, meaning a one-cycle pulse per second; it drives the colon blink.
REQ-008 SHALL have port an, output, 4, meaning active-low anodes; an[0] is the rightmost digit.
REQ-009 SHALL have port seg, output, 7, meaning active-low segments {g,f,e,d,c,b,a}.
REQ-010 SHALL have port dp, output, 1, meaning the active-low decimal point used as the colon.
REQ-011 SHALL have port frame_start, output, 1, meaning a one-cycle pulse on each snapshot load.

Function
REQ-012 SHALL hold slot counter cnt, which counts 0..REFRESH_DIV-1 and wraps to 0; terminal count (tc) is cnt==REFRESH_DIV-1.
REQ-013 SHALL hold a 2-bit digit index idx, which advances on tc in the order 0->1->2->3->0.
REQ-014 SHALL hold a load flag that is set by reset and on tc when idx==3, and cleared in the cycle a snapshot loads.
REQ-015 SHALL, when the load flag is 1, capture show_seconds and the four selected digits into snapshot registers and pulse frame_start for that one cycle.
REQ-016 SHALL take the selected digits as hrTens, hrOnes, minTens, minOnes when the captured mode is 0, and as minTens, minOnes, secTens, secOnes when the captured mode is 1; these map to idx 3, 2, 1, 0 respectively.
REQ-017 SHALL ignore input changes between snapshots; the display never mixes two frames (no tearing).
REQ-018 SHALL register an, seg and dp from idx and the snapshot, giving 1 cycle of latency after an idx change.
REQ-019 SHALL drive an as one-hot low at bit idx, with all other bits 1.
REQ-020 SHALL drive an=4'b1111 in the slot when idx==3, blank_lead_zero==1 (sampled live) and the snapshot digit is 0; seg is don't-care in that slot.
REQ-021 SHALL decode seg as 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000.
REQ-022 SHALL decode a digit value of 10..15 as dash 0111111, as the invalid-BCD indication.
REQ-023 SHALL hold colon_phase, which toggles on each sec_tick; dp=0 only when idx==2 and colon_phase==1, otherwise dp=1.
REQ-024 SHALL toggle colon_phase exactly once when sec_tick coincides with tc or with a snapshot load.
REQ-025 SHALL apply a show_seconds or digit change mid-frame only at the next snapshot.

Reset
REQ-026 SHALL, while reset is high, immediately force an=1111, seg=1111111, dp=1, frame_start=0, cnt=0, idx=0, colon_phase=0, snapshot=0, load flag=1.
REQ-027 SHALL, on the first edge after reset release, load the snapshot and pulse frame_start; an=1110 appears on that edge and shows the pre-load snapshot (0) for that one cycle.
REQ-028 SHALL, on reset assertion mid-frame, abort the scan with no partial-state retention.

Verification (REFRESH_DIV=4)
REQ-029 SHALL verify: digits 12:34:56, show_seconds=0, release reset -> frame_start at the first edge; idx 0..3 show 4,3,2,1 (seg 0011001, 0110000, 0100100, 1111001), each held 4 cycles, an 1110 -> 1101 -> 1011 -> 0111.
REQ-030 SHALL verify: show_seconds toggled to 1 while idx==1 -> the current frame keeps HH:MM; the next frame shows 3,4,5,6 order per REQ-016 (idx0=6, idx3=3).
REQ-031 SHALL verify: hrTens=0, blank_lead_zero=1 -> an=1111 during the idx==3 slot; with blank_lead_zero=0 -> an=0111, seg=1000000.
REQ-032 SHALL verify: minOnes=4'hB -> a dash (0111111) in its slot; all other digits are unaffected.
REQ-033 SHALL verify: two sec_tick pulses, the second coincident with tc -> dp=0 only in the idx==2 slots between the ticks, then dp=1 again.
REQ-034 SHALL verify: reset asserted mid-slot at idx==2 -> outputs blank asynchronously before the next edge; after release the scan restarts at idx 0 with a fresh frame_start.

Source files
------------

// File: rtl/time_display_scan.sv
// Four-digit multiplexed 7-segment scanner for HH:MM / MM:SS with a per-frame snapshot (no tearing).
// Outputs are registered one cycle after the digit index; no backpressure, the scan is free-running.
module time_display_scan #(
  parameter int REFRESH_DIV = 100000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] hrTensDig,
  input  logic [3:0] hrOnesDig,
  input  logic [3:0] minTensDig,
  input  logic [3:0] minOnesDig,
  input  logic [3:0] secTensDig,
  input  logic [3:0] secOnesDig,
  input  logic       show_seconds,
  input  logic       blank_lead_zero,
  input  logic       sec_tick,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       frame_start
);

  localparam int CW = (REFRESH_DIV > 2) ? $clog2(REFRESH_DIV) : 1;

  logic [CW-1:0]   cnt;
  logic [1:0]      idx;
  logic            loadFlag;
  logic            colonPhase;
  logic [3:0][3:0] snapDig;
  logic [3:0][3:0] selDig;
  logic [3:0]      curDig;
  logic            tc;

  assign tc     = (cnt == CW'(REFRESH_DIV - 1));
  assign curDig = snapDig[idx];

  // The display mode is resolved at capture time, so the snapshot holds the
  // four digits already in scan order (element 3 = leftmost).
  always_comb begin
    selDig = {hrTensDig, hrOnesDig, minTensDig, minOnesDig};
    if (show_seconds)
      selDig = {minTensDig, minOnesDig, secTensDig, secOnesDig};
  end

  function automatic logic [6:0] decode(input logic [3:0] d);
    case (d)
      4'd0:    decode = 7'b1000000;
      4'd1:    decode = 7'b1111001;
      4'd2:    decode = 7'b0100100;
      4'd3:    decode = 7'b0110000;
      4'd4:    decode = 7'b0011001;
      4'd5:    decode = 7'b0010010;
      4'd6:    decode = 7'b0000010;
      4'd7:    decode = 7'b1111000;
      4'd8:    decode = 7'b0000000;
      4'd9:    decode = 7'b0010000;
      default: decode = 7'b0111111;
    endcase
  endfunction

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt         <= '0;
      idx         <= 2'd0;
      loadFlag    <= 1'b1;
      colonPhase  <= 1'b0;
      snapDig     <= '0;
      an          <= 4'b1111;
      seg         <= 7'b1111111;
      dp          <= 1'b1;
      frame_start <= 1'b0;
    end else begin
      cnt <= tc ? '0 : cnt + CW'(1);
      if (tc)
        idx <= idx + 2'd1;

      // Armed at the end of the last slot; the capture happens on the next edge.
      loadFlag    <= tc && (idx == 2'd3);
      frame_start <= loadFlag;
      if (loadFlag)
        snapDig <= selDig;

      if (sec_tick)
        colonPhase <= ~colonPhase;

      if (idx == 2'd3 && blank_lead_zero && curDig == 4'd0)
        an <= 4'b1111;
      else
        an <= ~(4'b0001 << idx);
      seg <= decode(curDig);
      dp  <= ~((idx == 2'd2) && colonPhase);
    end
  end

endmodule

// File: tb/tb_time_display_scan.sv
// Scoreboard bench for time_display_scan with REFRESH_DIV=4 (16 edges per frame).
module tb_time_display_scan;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] hrTensDig, hrOnesDig, minTensDig, minOnesDig, secTensDig, secOnesDig;
  logic       show_seconds, blank_lead_zero, sec_tick;
  logic [3:0] an;
  logic [6:0] seg;
  logic       dp, frame_start;

  time_display_scan #(.REFRESH_DIV(4)) dut (
    .clk(clk), .reset(reset),
    .hrTensDig(hrTensDig), .hrOnesDig(hrOnesDig),
    .minTensDig(minTensDig), .minOnesDig(minOnesDig),
    .secTensDig(secTensDig), .secOnesDig(secOnesDig),
    .show_seconds(show_seconds), .blank_lead_zero(blank_lead_zero), .sec_tick(sec_tick),
    .an(an), .seg(seg), .dp(dp), .frame_start(frame_start)
  );

  always #5 clk = ~clk;

  localparam logic [6:0] S0 = 7'b1000000, S1 = 7'b1111001, S2 = 7'b0100100,
                         S3 = 7'b0110000, S4 = 7'b0011001, S5 = 7'b0010010,
                         S6 = 7'b0000010, SD = 7'b0111111, SB = 7'b1111111;

  typedef struct {
    int         cyc;
    logic [3:0] an;
    logic [6:0] seg;
    logic       dp;
    logic       fs;
    bit         chkSeg;
    string      name;
  } exp_t;

  exp_t q[$];
  int   gcyc = 0;
  int   base = 0;
  int   compared = 0;
  int   mismatched = 0;

  always @(posedge clk) gcyc <= gcyc + 1;

  task automatic pushSlot(input int e0, input int n, input logic [3:0] a, input logic [6:0] s,
                          input logic d, input logic f, input bit cs, input string nm);
    exp_t r;
    for (int i = 0; i < n; i++) begin
      r.cyc = base + e0 + i; r.an = a; r.seg = s; r.dp = d; r.fs = f; r.chkSeg = cs; r.name = nm;
      q.push_back(r);
    end
  endtask

  task automatic toEdge(input int k);
    while (gcyc < base + k) @(negedge clk);
  endtask

  // Monitor: compares every queued expectation on the falling edge of its cycle.
  always @(negedge clk) begin
    exp_t e;
    bit ok;
    while (q.size() > 0 && q[0].cyc <= gcyc) begin
      e = q.pop_front();
      compared++;
      ok = (e.cyc == gcyc) && (an === e.an) && (dp === e.dp) && (frame_start === e.fs) &&
           (!e.chkSeg || seg === e.seg);
      if (!ok) begin
        mismatched++;
        $display("FAIL %s edge%0d: got an=%b seg=%b dp=%b fs=%b, want an=%b seg=%b dp=%b fs=%b",
                 e.name, e.cyc - base, an, seg, dp, frame_start, e.an, e.seg, e.dp, e.fs);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    {hrTensDig, hrOnesDig, minTensDig, minOnesDig, secTensDig, secOnesDig} = {4'd1, 4'd2, 4'd3, 4'd4, 4'd5, 4'd6};
    show_seconds = 1'b0; blank_lead_zero = 1'b0; sec_tick = 1'b0;
    #1 reset = 1'b1;
    pushSlot(2, 1, 4'b1111, SB, 1'b1, 1'b0, 1'b1, "reset_state");
    toEdge(3);
    base = gcyc;

    // Frame 0: 12:34 in HH:MM; first idx0 cycle shows the pre-load snapshot.
    pushSlot(1,  1, 4'b1110, S0, 1'b1, 1'b1, 1'b1, "f0_first");
    pushSlot(2,  3, 4'b1110, S4, 1'b1, 1'b0, 1'b1, "f0_idx0");
    pushSlot(5,  4, 4'b1101, S3, 1'b1, 1'b0, 1'b1, "f0_idx1");
    pushSlot(9,  4, 4'b1011, S2, 1'b1, 1'b0, 1'b1, "f0_idx2");
    pushSlot(13, 4, 4'b0111, S1, 1'b1, 1'b0, 1'b1, "f0_idx3");
    // Frame 1: MM:SS = 34:56.
    pushSlot(17, 1, 4'b1110, S4, 1'b1, 1'b1, 1'b1, "f1_first");
    pushSlot(18, 3, 4'b1110, S6, 1'b1, 1'b0, 1'b1, "f1_idx0");
    pushSlot(21, 4, 4'b1101, S5, 1'b1, 1'b0, 1'b1, "f1_idx1");
    pushSlot(25, 4, 4'b1011, S4, 1'b1, 1'b0, 1'b1, "f1_idx2");
    pushSlot(29, 4, 4'b0111, S3, 1'b1, 1'b0, 1'b1, "f1_idx3");
    // Frame 2: 02:34, leading zero blanked until blank_lead_zero drops mid-slot.
    pushSlot(33, 1, 4'b1110, S6, 1'b1, 1'b1, 1'b1, "f2_first");
    pushSlot(34, 3, 4'b1110, S4, 1'b1, 1'b0, 1'b1, "f2_idx0");
    pushSlot(37, 4, 4'b1101, S3, 1'b1, 1'b0, 1'b1, "f2_idx1");
    pushSlot(41, 4, 4'b1011, S2, 1'b1, 1'b0, 1'b1, "f2_idx2");
    pushSlot(45, 2, 4'b1111, SB, 1'b1, 1'b0, 1'b0, "f2_blank");
    pushSlot(47, 2, 4'b0111, S0, 1'b1, 1'b0, 1'b1, "f2_zero");
    // Frame 3: 02:3B -> dash in idx0; colon lit in idx2 after the first tick.
    pushSlot(49, 1, 4'b1110, S4, 1'b1, 1'b1, 1'b1, "f3_first");
    pushSlot(50, 3, 4'b1110, SD, 1'b1, 1'b0, 1'b1, "f3_dash");
    pushSlot(53, 4, 4'b1101, S3, 1'b1, 1'b0, 1'b1, "f3_idx1");
    pushSlot(57, 4, 4'b1011, S2, 1'b0, 1'b0, 1'b1, "f3_colon_on");
    pushSlot(61, 4, 4'b0111, S0, 1'b1, 1'b0, 1'b1, "f3_idx3");
    // Frame 4: second tick landed on tc, colon off again.
    pushSlot(65, 1, 4'b1110, SD, 1'b1, 1'b1, 1'b1, "f4_first");
    pushSlot(66, 3, 4'b1110, SD, 1'b1, 1'b0, 1'b1, "f4_dash");
    pushSlot(69, 4, 4'b1101, S3, 1'b1, 1'b0, 1'b1, "f4_idx1");
    pushSlot(73, 4, 4'b1011, S2, 1'b1, 1'b0, 1'b1, "f4_colon_off");
    pushSlot(77, 4, 4'b0111, S0, 1'b1, 1'b0, 1'b1, "f4_idx3");
    // Frame 5: third tick lights the colon, then reset lands inside the idx2 slot.
    pushSlot(81, 1, 4'b1110, SD, 1'b1, 1'b1, 1'b1, "f5_first");
    pushSlot(82, 3, 4'b1110, SD, 1'b1, 1'b0, 1'b1, "f5_dash");
    pushSlot(85, 4, 4'b1101, S3, 1'b1, 1'b0, 1'b1, "f5_idx1");
    pushSlot(89, 1, 4'b1011, S2, 1'b0, 1'b0, 1'b1, "f5_colon");
    pushSlot(90, 3, 4'b1111, SB, 1'b1, 1'b0, 1'b1, "midreset_blank");
    reset = 1'b0;

    toEdge(5);  show_seconds = 1'b1;
    toEdge(20); show_seconds = 1'b0; hrTensDig = 4'd0; blank_lead_zero = 1'b1;
    toEdge(40); minOnesDig = 4'hB;
    toEdge(46); blank_lead_zero = 1'b0;
    toEdge(51); sec_tick = 1'b1;
    toEdge(52); sec_tick = 1'b0;
    toEdge(71); sec_tick = 1'b1;
    toEdge(72); sec_tick = 1'b0;
    toEdge(83); sec_tick = 1'b1;
    toEdge(84); sec_tick = 1'b0;
    toEdge(89);
    @(posedge clk);
    #1 reset = 1'b1;
    toEdge(92);
    base = gcyc;

    // Restart: fresh frame_start, snapshot and colon phase cleared.
    pushSlot(1,  1, 4'b1110, S0, 1'b1, 1'b1, 1'b1, "rst2_first");
    pushSlot(2,  3, 4'b1110, SD, 1'b1, 1'b0, 1'b1, "rst2_idx0");
    pushSlot(5,  4, 4'b1101, S3, 1'b1, 1'b0, 1'b1, "rst2_idx1");
    pushSlot(9,  4, 4'b1011, S2, 1'b1, 1'b0, 1'b1, "rst2_colon_clr");
    pushSlot(13, 4, 4'b0111, S0, 1'b1, 1'b0, 1'b1, "rst2_idx3");
    pushSlot(17, 1, 4'b1110, SD, 1'b1, 1'b1, 1'b1, "rst2_f1");
    reset = 1'b0;

    for (int i = 0; i < 200 && q.size() > 0; i++) @(negedge clk);
    #1;
    if (q.size() > 0) begin
      compared++;
      mismatched++;
      $display("FAIL drain: %0d expectations left, want 0", q.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
